// File: rtl/sort_pkg.sv
// Definitions shared by the 3-input sorter, its serializer and their benches:
// default element width, serializer element index and the sorted-triple layout.
package sort_pkg;

    localparam int SORT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDX0 = 2'd0,
        IDX1 = 2'd1,
        IDX2 = 2'd2
    } idx_e;

    typedef struct packed {
        logic [SORT_WIDTH-1:0] no1;
        logic [SORT_WIDTH-1:0] no2;
        logic [SORT_WIDTH-1:0] no3;
    } triple_t;

    function automatic idx_e idx_next(input idx_e i);
        case (i)
            IDX0:    idx_next = IDX1;
            IDX1:    idx_next = IDX2;
            default: idx_next = IDX0;
        endcase
    endfunction

endpackage

// File: rtl/triple_fifo.sv
// Triple-wide FIFO: DEPTH entries of {no1,no2,no3}, occupancy-counter full/empty,
// head entry presented combinationally.
module triple_fifo
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [3*WIDTH-1:0]   i_wdata,
    input  logic                 i_pop,
    output logic [3*WIDTH-1:0]   o_rdata,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3*WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/sort_serializer.sv
// Buffers sorted triples and replays them as a valid/ready element stream with a
// last-of-triple flag, a sticky sort-order error and an emitted-triple counter.
module sort_serializer
    import sort_pkg::*;
#(
    parameter int WIDTH   = SORT_WIDTH,
    parameter int DEPTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] no1,
    input  logic [WIDTH-1:0] no2,
    input  logic [WIDTH-1:0] no3,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             order_err,
    output logic [15:0]      triple_cnt
);

    idx_e               r_idx;
    logic               r_order_err;
    logic [15:0]        r_triple_cnt;

    logic [3*WIDTH-1:0] w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_fire;
    logic               w_pop;
    logic               w_bad_order;

    assign w_push = in_valid && !w_full;
    assign w_fire = !w_empty && out_ready;
    assign w_pop  = w_fire && (r_idx == IDX2);

    // Unsigned compares; ties are legal in either direction.
    assign w_bad_order = DESCEND ? ((no1 < no2) || (no2 < no3))
                                 : ((no1 > no2) || (no2 > no3));

    triple_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({no1, no2, no3}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= IDX0;
            r_order_err  <= 1'b0;
            r_triple_cnt <= '0;
        end else begin
            if (w_fire) r_idx <= idx_next(r_idx);
            if (w_pop)  r_triple_cnt <= r_triple_cnt + 16'd1;
            if (w_push && w_bad_order) r_order_err <= 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        if (!w_empty) begin
            case (r_idx)
                IDX0:    out_data = w_rdata[3*WIDTH-1 -: WIDTH];
                IDX1:    out_data = w_rdata[2*WIDTH-1 -: WIDTH];
                default: out_data = w_rdata[WIDTH-1:0];
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_last   = (r_idx == IDX2) && !w_empty;
    assign order_err  = r_order_err;
    assign triple_cnt = r_triple_cnt;

endmodule

// File: tb/tb_sort_serializer.sv
// Randomized and directed bench for sort_serializer against an element-queue model.
module tb_sort_serializer;
    import sort_pkg::*;

    localparam int W = SORT_WIDTH;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [W-1:0] no1, no2, no3;
    logic         in_ready, out_valid, out_last, order_err;
    logic [W-1:0] out_data;
    logic [15:0]  triple_cnt;

    logic         d_in_valid;
    logic [W-1:0] d_no1, d_no2, d_no3;
    logic         d_in_ready, d_out_valid, d_out_last, d_order_err;
    logic [W-1:0] d_out_data;
    logic [15:0]  d_triple_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: flat queue of elements still to be emitted, in push order.
    int unsigned q[$];
    int          m_err = 0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    sort_serializer #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .no1(no1), .no2(no2), .no3(no3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .order_err(order_err),
        .triple_cnt(triple_cnt)
    );

    sort_serializer #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b1)) u_dut_desc (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .no1(d_no1), .no2(d_no2), .no3(d_no3),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_last(d_out_last), .out_ready(1'b1), .order_err(d_order_err),
        .triple_cnt(d_triple_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs with the model, then advance the model across the edge.
    task automatic cycle();
        int  occ;
        bit  push, pop;
        @(negedge clk);
        occ = (q.size() + 2) / 3;
        chk("in_ready",   {31'd0, in_ready},   {31'd0, occ < D});
        chk("out_valid",  {31'd0, out_valid},  {31'd0, q.size() != 0});
        chk("out_data",   {29'd0, out_data},   (q.size() != 0) ? q[0] : 0);
        chk("out_last",   {31'd0, out_last},   {31'd0, (q.size() % 3) == 1});
        chk("order_err",  {31'd0, order_err},  m_err);
        chk("triple_cnt", {16'd0, triple_cnt}, m_cnt);
        push = in_valid && (occ < D);
        pop  = out_ready && (q.size() != 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 0;
            m_cnt = 0;
        end else begin
            if (pop) begin
                if ((q.size() % 3) == 1) m_cnt = (m_cnt + 1) % 65536;
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back(no1);
                q.push_back(no2);
                q.push_back(no3);
                if ((no1 > no2) || (no2 > no3)) m_err = 1;
            end
        end
        #1;
    endtask

    task automatic push1(input int a, input int b, input int c, input bit rdy);
        in_valid  = 1'b1;
        no1 = W'(a); no2 = W'(b); no3 = W'(c);
        out_ready = rdy;
        cycle();
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        in_valid  = 1'b0;
        out_ready = rdy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        no1 = '0; no2 = '0; no3 = '0;
        d_in_valid = 1'b0; d_no1 = '0; d_no2 = '0; d_no3 = '0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_data", {29'd0, out_data}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        // Single triple
        push1(1, 4, 6, 1'b1);
        idle(4, 1'b1);
        chk("single_cnt", {16'd0, triple_cnt}, 1);

        // Backpressure stall then drain
        push1(2, 2, 7, 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b1);

        // Fill to DEPTH, drop a fifth push, then release
        for (int t = 0; t < D; t++) push1(t, t + 1, t + 3, 1'b0);
        chk("fill_in_ready", {31'd0, in_ready}, 0);
        push1(0, 0, 0, 1'b0);
        idle(14, 1'b1);
        chk("fill_cnt", {16'd0, triple_cnt}, 6);

        // Order error is sticky and the triple is still emitted
        push1(5, 3, 7, 1'b1);
        chk("order_err_set", {31'd0, order_err}, 1);
        idle(5, 1'b1);

        // Full with final-element pop, then sustained input across wrap-around
        for (int t = 0; t < D; t++) push1(t, 4, 7 - t / 2, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 9 * D; i++) begin
            no1 = W'($urandom_range(0, 2));
            no2 = W'($urandom_range(2, 4));
            no3 = W'($urandom_range(4, 7));
            cycle();
        end
        idle(15, 1'b1);

        // Reset mid-triple
        push1(3, 5, 6, 1'b1);
        idle(1, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 0);
        chk("midrst_cnt",   {16'd0, triple_cnt}, 0);
        push1(0, 1, 2, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic with occasional violations and resets
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            no1 = W'($urandom); no2 = W'($urandom); no3 = W'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (no1 > no2) begin no2 = no1; end
                if (no2 > no3) begin no3 = no2; end
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(15, 1'b1);

        // Descending build: ties allowed, inversions flagged
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        d_in_valid = 1'b1; d_no1 = 3'd7; d_no2 = 3'd7; d_no3 = 3'd0;
        @(posedge clk); #1; d_in_valid = 1'b0;
        @(negedge clk);
        chk("desc_tie_ok", {31'd0, d_order_err}, 0);
        d_in_valid = 1'b1; d_no1 = 3'd1; d_no2 = 3'd2; d_no3 = 3'd0;
        @(posedge clk); #1; d_in_valid = 1'b0;
        @(negedge clk);
        chk("desc_err", {31'd0, d_order_err}, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
